pio_input_debouncer: RTL and testbench
======================================

# pio_input_debouncer

Conditions raw board inputs (slide switches, push buttons) before they reach the Avalon input PIO's `in_port`. The block synchronises each bit into `clk`, debounces each bit independently with a saturating-window counter, and presents a stable bus plus one-cycle edge pulses. The PIO then samples only settled, metastability-free levels.

## Interface
Parameters:
- `WIDTH`, 8: number of input channels; matches the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a level is accepted (1 ms at 50 MHz). Legal range is 1 .. 2^`CNT_W`.
- `CNT_W`, 16: width of each channel's counter.
- `RESET_VAL`, 0 (`WIDTH` bits): reset level of the synchroniser and debounced registers. Set to all-ones for active-low buttons.

Ports:
- `clk` input 1: system clock. All logic is on rising edges.
- `reset_n` input 1: reset, asynchronous, active-low.
- `raw_in` input `WIDTH`: asynchronous pin levels.
- `debounced_out` output `WIDTH`: accepted levels, registered. Feeds the PIO `in_port`.
- `rise_pulse` output `WIDTH`: one-cycle high when the matching `debounced_out` bit goes 0→1.
- `fall_pulse` output `WIDTH`: one-cycle high when the matching bit goes 1→0.
- `changed_any` output 1: registered OR of all rise and fall conditions. Asserted in the same cycle as the pulses.

## Operation
- Per channel, a two-flop synchroniser: `s1 <= raw_in[i]`, then `s2 <= s1`. Only `s2` is used downstream.
- Per channel, a state `db` (which drives `debounced_out[i]`) and a counter `cnt` (`CNT_W` bits), evaluated on every edge:
  - `s2 == db`: `cnt <= 0`, no pulse.
  - `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`, and the rise or fall pulse for that bit is 1 on the next cycle.
  - `s2 != db` otherwise: `cnt <= cnt+1`.
- Any disagreement shorter than `DEBOUNCE_CYCLES` consecutive evaluations resets `cnt` and is rejected. `db` never changes.
- Counters never wrap. A counter can only reach `DEBOUNCE_CYCLES-1`, then it clears.
- Channels are fully independent. Any number of bits may toggle, and pulse, on the same edge.
- Pulse outputs are registered and computed from the same transition condition. They are never derived by comparing `debounced_out` against a delayed copy.
- Reset values: `s1`, `s2` and `db` are `RESET_VAL`; `cnt` is 0; `rise_pulse`, `fall_pulse` and `changed_any` are 0.
- Reset mid-count discards the partial count. After reset release, an input already differing from `RESET_VAL` takes the full latency to be accepted, and produces its pulse when accepted.

## Timing
- Let edge 1 be the first rising edge that captures a new, clean `raw_in` level into `s1`.
- `s2` differs from `db` after edge 2.
- `debounced_out` and the pulse register update on edge `DEBOUNCE_CYCLES+2`.
  - With `DEBOUNCE_CYCLES=1`: edge 3.
  - With `DEBOUNCE_CYCLES=4`: edge 6.
- Pulses are high for exactly one cycle. They deassert on the following edge, even if another transition on the same bit is already counting.
- Minimum spacing between two accepted transitions on one bit is `DEBOUNCE_CYCLES` cycles.
- `raw_in` has no setup/hold relation to `clk`. The path into `s1` is a false path; `s1`→`s2` must be placed adjacent.
- No combinational path from any input to any output.

## Structure
- Shared package `pio_cond_pkg` holds:
  - the defaults `PIO_WIDTH=8`, `DEBOUNCE_CYCLES_DEFAULT=50000` and `DEBOUNCE_CNT_W=16`;
  - the simulation constant `DEBOUNCE_CYCLES_SIM=4`.
- One sub-module, `debounce_channel`, holds `s1`, `s2`, `db`, `cnt` and the rise/fall flops for a single bit. The top instantiates it `WIDTH` times via generate and builds `changed_any` as a registered OR.
- Elaboration-time check: fail if `DEBOUNCE_CYCLES < 1` or `DEBOUNCE_CYCLES > 2^CNT_W`.

## Test plan
All scenarios use `WIDTH=8`, `DEBOUNCE_CYCLES=4`, `RESET_VAL=0`.

1. Reset: `reset_n` low with `raw_in=0xFF` → all outputs 0. Release → `debounced_out=0xFF` on edge 6 after release, with `rise_pulse=0xFF` and `changed_any=1` for one cycle.
2. Clean step: `raw_in` 0x00→0x01 → `debounced_out=0x01` on edge 6, `rise_pulse=0x01` for one cycle. Step back 0x01→0x00 → `fall_pulse=0x01` for one cycle, 6 edges later.
3. Glitch rejection: bit 3 high for 3 cycles, then low → `debounced_out` stays 0x00, no pulses. Bit 3 high for 4 cycles → accepted, `rise_pulse=0x08`.
4. Bounce: bit 0 toggles every cycle for 20 cycles, then holds 1 → exactly one `rise_pulse[0]`, 6 edges after the final toggle is captured.
5. Simultaneous channels: `raw_in` 0x00→0xA5 in one cycle → `debounced_out=0xA5` on one edge, `rise_pulse=0xA5`, `changed_any` a single one-cycle pulse.
6. Reset mid-count: bit 2 rises, `reset_n` asserted after 2 counting cycles then released with bit 2 still high → no pulse before release; `debounced_out=0x04` on edge 6 after release.

Source files
------------

// File: rtl/pio_cond_pkg.sv
// Shared defaults and helpers for the PIO input conditioning blocks.
package pio_cond_pkg;

  localparam int unsigned PIO_WIDTH               = 32'd8;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd50000;
  localparam int unsigned DEBOUNCE_CNT_W          = 32'd16;
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 32'd4;

  // Transition a channel will report on the next edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  // True when a counter of cnt_w bits can reach cycles-1 without wrapping.
  function automatic logic cycles_in_range(input int unsigned cycles,
                                           input int unsigned cnt_w);
    longint unsigned limit;
    limit = 64'd1 << cnt_w;
    return (cycles >= 32'd1) && (longint'(cycles) <= limit);
  endfunction

endpackage

// File: rtl/pio_input_debouncer_channel.sv
// Single-bit conditioner: two-flop synchroniser, saturating-window debounce
// counter and registered rise/fall pulses.
module debounce_channel
  import pio_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W,
  parameter logic        RESET_BIT       = 1'b0
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  raw_in,
  output logic  debounced_out,
  output logic  rise_pulse,
  output logic  fall_pulse,
  output edge_e edge_d_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             fall_q;
  edge_e            edge_d;

  // Debounce decision: any agreement clears the window, a full window flips db.
  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    edge_d = EDGE_NONE;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      db_d   = s2_q;
      edge_d = s2_q ? EDGE_RISE : EDGE_FALL;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; s1 samples an asynchronous pin and is a false-path endpoint.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= RESET_BIT;
      s2_q   <= RESET_BIT;
      db_q   <= RESET_BIT;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= raw_in;
      s2_q   <= s1_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= (edge_d == EDGE_RISE);
      fall_q <= (edge_d == EDGE_FALL);
    end
  end

  assign debounced_out = db_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign edge_d_o      = edge_d;

endmodule

// File: rtl/pio_input_debouncer.sv
// Conditions raw switch/button pins for an Avalon input PIO: per-bit sync and
// debounce, plus edge pulses and a registered any-change flag.
module pio_input_debouncer
  import pio_cond_pkg::*;
#(
  parameter int unsigned     WIDTH           = PIO_WIDTH,
  parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned     CNT_W           = DEBOUNCE_CNT_W,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed_any
);

  if (!cycles_in_range(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("pio_input_debouncer: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W");
  end

  edge_e            edge_d_s [WIDTH];
  logic [WIDTH-1:0] change_d_s;
  logic             changed_any_d;
  logic             changed_any_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_BIT       (RESET_VAL[i])
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw_in        (raw_in[i]),
      .debounced_out (debounced_out[i]),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i]),
      .edge_d_o      (edge_d_s[i])
    );
    assign change_d_s[i] = (edge_d_s[i] != EDGE_NONE);
  end

  // Built from the same next-state conditions as the pulses so it lines up with them.
  assign changed_any_d = |change_d_s;

  // Any-change flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_any_q <= 1'b0;
    end else begin
      changed_any_q <= changed_any_d;
    end
  end

  assign changed_any = changed_any_q;

endmodule

// File: tb/tb_pio_input_debouncer.sv
// Self-checking bench: directed scenarios plus random toggling, checked against
// a window-based reference model of the debounce rule.
module tb_pio_input_debouncer;
  import pio_cond_pkg::*;

  localparam int W  = 8;
  localparam int DC = int'(DEBOUNCE_CYCLES_SIM);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] raw_in = 8'h00;
  logic [W-1:0] debounced_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         changed_any;

  always #5 clk = ~clk;

  pio_input_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
    .CNT_W           (16),
    .RESET_VAL       (8'h00)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .raw_in        (raw_in),
    .debounced_out (debounced_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .changed_any   (changed_any)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: history of pin levels seen at each edge since reset.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] eval_hist[$];
  logic [W-1:0] db_m, rise_m, fall_m;
  logic         chg_m;

  int rise_cnt[W];
  int fall_cnt[W];
  int chg_cnt;
  int edge_in_run;
  int first_chg;
  logic [W-1:0] rise_first, fall_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw_hist = {8'h00, 8'h00};
    eval_hist.delete();
    db_m   = 8'h00;
    rise_m = 8'h00;
    fall_m = 8'h00;
    chg_m  = 1'b0;
  endtask

  task automatic clear_stats();
    for (int b = 0; b < W; b++) begin
      rise_cnt[b] = 0;
      fall_cnt[b] = 0;
    end
    chg_cnt = 0;
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic tick();
    logic [W-1:0] ev;
    logic [W-1:0] acc;
    logic         all_diff;
    @(posedge clk);
    if (reset_n) begin
      ev = raw_hist[raw_hist.size()-2];
      raw_hist.push_back(raw_in);
      eval_hist.push_back(ev);
      acc = 8'h00;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b0;
        if (eval_hist.size() >= DC) begin
          all_diff = 1'b1;
          for (int k = 0; k < DC; k++) begin
            if (eval_hist[eval_hist.size()-1-k][b] == db_m[b]) all_diff = 1'b0;
          end
        end
        acc[b] = all_diff;
      end
      rise_m = acc & ~db_m;
      fall_m = acc & db_m;
      db_m   = db_m ^ acc;
      chg_m  = |acc;
    end
    #1;
    edge_in_run++;
    chk("debounced_out", 32'(debounced_out), 32'(db_m));
    chk("rise_pulse",    32'(rise_pulse),    32'(rise_m));
    chk("fall_pulse",    32'(fall_pulse),    32'(fall_m));
    chk("changed_any",   32'(changed_any),   32'(chg_m));
    if (changed_any && first_chg == 0) begin
      first_chg  = edge_in_run;
      rise_first = rise_pulse;
      fall_first = fall_pulse;
    end
    if (changed_any) chg_cnt++;
    for (int b = 0; b < W; b++) begin
      if (rise_pulse[b]) rise_cnt[b]++;
      if (fall_pulse[b]) fall_cnt[b]++;
    end
  endtask

  task automatic run(input logic [W-1:0] val, input int n);
    raw_in      = val;
    edge_in_run = 0;
    first_chg   = 0;
    rise_first  = 8'h00;
    fall_first  = 8'h00;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("reset_debounced", 32'(debounced_out), 32'h0);
    chk("reset_pulses",    32'({rise_pulse, fall_pulse}), 32'h0);
    chk("reset_changed",   32'(changed_any), 32'h0);
  endtask

  initial begin
    logic [W-1:0] mask;
    model_reset();
    clear_stats();
    edge_in_run = 0;
    first_chg = 0;

    // 1: reset with all pins high, then release.
    raw_in = 8'hFF;
    do_reset();
    tick();
    tick();
    reset_n = 1'b1;
    run(8'hFF, 8);
    chk("s1_latency",   32'(first_chg),     32'd6);
    chk("s1_rise_mask", 32'(rise_first),    32'hFF);
    chk("s1_chg_count", 32'(chg_cnt),       32'd1);
    chk("s1_level",     32'(debounced_out), 32'hFF);

    // 2: clean step up and back down on bit 0.
    run(8'h00, 10);
    clear_stats();
    run(8'h01, 10);
    chk("s2_rise_latency", 32'(first_chg),  32'd6);
    chk("s2_rise_mask",    32'(rise_first), 32'h01);
    run(8'h00, 10);
    chk("s2_fall_latency", 32'(first_chg),  32'd6);
    chk("s2_fall_mask",    32'(fall_first), 32'h01);
    chk("s2_chg_count",    32'(chg_cnt),    32'd2);

    // 3: three-cycle glitch rejected, four-cycle pulse accepted.
    clear_stats();
    run(8'h08, 3);
    run(8'h00, 10);
    chk("s3_glitch_chg",   32'(chg_cnt),       32'd0);
    chk("s3_glitch_level", 32'(debounced_out), 32'h00);
    run(8'h08, 4);
    run(8'h00, 12);
    chk("s3_rise_bit3", 32'(rise_cnt[3]), 32'd1);
    chk("s3_fall_bit3", 32'(fall_cnt[3]), 32'd1);
    chk("s3_chg_count", 32'(chg_cnt),     32'd2);

    // 4: bounce on bit 0, then a steady high.
    clear_stats();
    for (int i = 0; i < 20; i++) run((i % 2 == 0) ? 8'h01 : 8'h00, 1);
    run(8'h01, 12);
    chk("s4_latency",   32'(first_chg),   32'd6);
    chk("s4_rise_bit0", 32'(rise_cnt[0]), 32'd1);
    chk("s4_chg_count", 32'(chg_cnt),     32'd1);

    // 5: several channels accepted on the same edge.
    run(8'h00, 10);
    clear_stats();
    run(8'hA5, 10);
    chk("s5_latency",   32'(first_chg),     32'd6);
    chk("s5_rise_mask", 32'(rise_first),    32'hA5);
    chk("s5_chg_count", 32'(chg_cnt),       32'd1);
    chk("s5_level",     32'(debounced_out), 32'hA5);

    // 6: reset in the middle of a count.
    run(8'h00, 10);
    clear_stats();
    run(8'h04, 4);
    do_reset();
    chk("s6_no_early_pulse", 32'(chg_cnt), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    run(8'h04, 8);
    chk("s6_latency",   32'(first_chg),     32'd6);
    chk("s6_rise_mask", 32'(rise_first),    32'h04);
    chk("s6_level",     32'(debounced_out), 32'h04);

    // Random toggling with sparse per-bit flips and one reset in the middle.
    clear_stats();
    for (int i = 0; i < 600; i++) begin
      mask = 8'h00;
      for (int b = 0; b < W; b++) mask[b] = ($urandom_range(0, 7) == 0);
      if (i % 50 >= 35) mask = 8'h00;
      raw_in = raw_in ^ mask;
      if (i == 300) begin
        do_reset();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
